// File: rtl/sonar_echo_timer.sv
// HC-SR04 style ultrasonic ranger front end: trigger pulse, echo width in microseconds, timeout flag.
// Optional feature macro SONAR_AUTO_RETRIGGER_EN: free-running ranging, start is ignored.
module sonar_echo_timer #(
    parameter int unsigned US_DIV      = 50,
    parameter int unsigned TRIG_CYCLES = 500,
    parameter int unsigned TIMEOUT_US  = 30000,
    parameter int unsigned HOLDOFF_US  = 10000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        echo_in,
    output logic        trig_out,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] echo_us
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_MEASURE   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int TW = (TRIG_CYCLES > 1) ? $clog2(TRIG_CYCLES) : 1;

    localparam logic [PW-1:0] PRESC_LAST  = PW'(US_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE   = PW'(1);
    localparam logic [TW-1:0] TRIG_LAST   = TW'(TRIG_CYCLES - 1);
    localparam logic [TW-1:0] TRIG_ONE    = TW'(1);
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT_US);
    localparam logic [15:0]   HOLD_LAST   = 16'(HOLDOFF_US - 1);

    logic [2:0]    state_q, state_d;
    logic          echo_meta_q, echo_sync_q, echo_dly_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] trig_cnt_q, trig_cnt_d;
    logic [15:0]   us_q, us_d;
    logic          trig_q, trig_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   echo_us_q, echo_us_d;
    logic          tick_s, rise_s, fall_s;

    // Next-state, prescaler and saturating microsecond counter.
    always_comb begin
        tick_s     = (presc_q == PRESC_LAST);
        rise_s     = echo_sync_q & ~echo_dly_q;
        fall_s     = ~echo_sync_q & echo_dly_q;
        state_d    = state_q;
        presc_d    = tick_s ? '0 : (presc_q + PRESC_ONE);
        us_d       = (tick_s && (us_q != 16'hFFFF)) ? (us_q + 16'd1) : us_q;
        trig_cnt_d = '0;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        echo_us_d  = echo_us_q;
        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                us_d    = 16'd0;
`ifdef SONAR_AUTO_RETRIGGER_EN
                state_d = S_TRIG;
`else
                if (start) begin
                    state_d = S_TRIG;
                end else begin
                    state_d = S_IDLE;
                end
`endif
            end
            S_TRIG: begin
                // Counters held at zero so WAIT_RISE starts from a clean microsecond boundary.
                presc_d = '0;
                us_d    = 16'd0;
                if (trig_cnt_q == TRIG_LAST) begin
                    state_d = S_WAIT_RISE;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRIG_ONE;
                end
            end
            S_WAIT_RISE: begin
                if (rise_s) begin
                    state_d = S_MEASURE;
                    presc_d = '0;
                    us_d    = 16'd0;
                end else if (us_q >= TIMEOUT_CNT) begin
                    state_d   = S_HOLDOFF;
                    presc_d   = '0;
                    us_d      = 16'd0;
                    echo_us_d = 16'hFFFF;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    state_d = S_WAIT_RISE;
                end
            end
            S_MEASURE: begin
                if (fall_s) begin
                    state_d   = S_HOLDOFF;
                    presc_d   = '0;
                    us_d      = 16'd0;
                    echo_us_d = us_q;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                end else if (us_q >= TIMEOUT_CNT) begin
                    state_d   = S_HOLDOFF;
                    presc_d   = '0;
                    us_d      = 16'd0;
                    echo_us_d = 16'hFFFF;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end else begin
                    state_d = S_MEASURE;
                end
            end
            S_HOLDOFF: begin
                if (tick_s && (us_q >= HOLD_LAST)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLDOFF;
                end
            end
            default: begin
                state_d = S_IDLE;
                presc_d = '0;
                us_d    = 16'd0;
            end
        endcase
        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
    end

    // State, echo synchronizer and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_dly_q  <= 1'b0;
            presc_q     <= '0;
            trig_cnt_q  <= '0;
            us_q        <= 16'd0;
            trig_q      <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            echo_us_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            echo_meta_q <= echo_in;
            echo_sync_q <= echo_meta_q;
            echo_dly_q  <= echo_sync_q;
            presc_q     <= presc_d;
            trig_cnt_q  <= trig_cnt_d;
            us_q        <= us_d;
            trig_q      <= trig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            echo_us_q   <= echo_us_d;
        end
    end

    assign trig_out = trig_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;
    assign echo_us  = echo_us_q;

endmodule
